// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants and state type for the motion-estimation search controller
package me_pkg;
  localparam int BLK     = 16;
  localparam int WIN     = 31;
  localparam int AW_R    = 8;
  localparam int AW_S    = 10;
  localparam int CNT_W   = 12;
  localparam int PE_LAT  = 1;
  localparam int CMP_LAT = 1;
  // The last PE sum reaches the comparator this many cycles after the final issue.
  localparam int DRAIN_LEN = PE_LAT + CMP_LAT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} me_state_t;
endpackage

// File: rtl/me_addr_gen.sv
// rtl/me_addr_gen.sv - combinational decode of the search counter into ROM addresses and pass flags
module me_addr_gen
  import me_pkg::*;
(
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  output logic [AW_R-1:0]  o_addr_r,
  output logic [AW_S-1:0]  o_addr_s1,
  output logic [AW_S-1:0]  o_addr_s2,
  output logic             o_first,
  output logic             o_last
);
  localparam int SW = AW_S + 1;

  logic [3:0]  w_vy;
  logic [3:0]  w_r;
  logic [3:0]  w_c;
  logic [SW-1:0] w_row;
  logic [SW-1:0] w_base;

  assign w_vy = i_cnt[11:8];
  assign w_r  = i_cnt[7:4];
  assign w_c  = i_cnt[3:0];

  // Window row holding reference row r at candidate offset vy.
  assign w_row  = SW'(w_vy) + SW'(w_r);
  assign w_base = w_row * SW'(WIN);

  assign o_addr_r  = i_en ? i_cnt[AW_R-1:0] : '0;
  assign o_addr_s1 = i_en ? AW_S'(w_base + SW'(w_c)) : '0;
  assign o_addr_s2 = i_en ? AW_S'(w_base + SW'(w_c) + SW'(BLK - 1)) : '0;
  assign o_first   = i_en && (i_cnt[AW_R-1:0] == '0);
  assign o_last    = i_en && (i_cnt[AW_R-1:0] == '1);
endmodule

// File: rtl/me_search_ctrl.sv
// rtl/me_search_ctrl.sv - full-search sequencer: FSM, pass counter and PE/comparator timing pipeline
module me_search_ctrl
  import me_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  output logic [AW_R-1:0] AddressR,
  output logic [AW_S-1:0] AddressS1,
  output logic [AW_S-1:0] AddressS2,
  output logic            pe_valid,
  output logic            pe_first,
  output logic            pe_last,
  output logic            cmp_en,
  output logic [3:0]      cmp_vy,
  output logic            busy,
  output logic            completed
);
  me_state_t        r_state;
  me_state_t        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_drain;
  logic             w_run;
  logic             w_first;
  logic             w_last;
  logic             r_pe_valid;
  logic             r_pe_first;
  logic             r_pe_last;
  logic [3:0]       r_vy_d1;
  logic             r_cmp_en;
  logic [3:0]       r_cmp_vy;

  assign w_run = (r_state == RUN);

  me_addr_gen u_addr_gen (
    .i_en      (w_run),
    .i_cnt     (r_cnt),
    .o_addr_r  (AddressR),
    .o_addr_s1 (AddressS1),
    .o_addr_s2 (AddressS2),
    .o_first   (w_first),
    .o_last    (w_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_run ? r_cnt + 1'b1 : '0;
      r_drain <= (r_state == DRAIN) ? r_drain + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_cnt == '1) w_next = DRAIN;
      DRAIN:   if (r_drain == 2'(DRAIN_LEN - 1)) w_next = DONE;
      DONE:    if (!start) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Issue flags follow the ROM read by one cycle, the comparator strobe trails pe_last by one more.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pe_valid <= 1'b0;
      r_pe_first <= 1'b0;
      r_pe_last  <= 1'b0;
      r_vy_d1    <= '0;
      r_cmp_en   <= 1'b0;
      r_cmp_vy   <= '0;
    end else begin
      r_pe_valid <= w_run;
      r_pe_first <= w_first;
      r_pe_last  <= w_last;
      r_vy_d1    <= w_run ? r_cnt[11:8] : 4'd0;
      r_cmp_en   <= r_pe_valid & r_pe_last;
      r_cmp_vy   <= r_vy_d1;
    end
  end

  assign pe_valid  = r_pe_valid;
  assign pe_first  = r_pe_first;
  assign pe_last   = r_pe_last;
  assign cmp_en    = r_cmp_en;
  assign cmp_vy    = r_cmp_vy;
  assign busy      = (r_state == RUN) || (r_state == DRAIN);
  assign completed = (r_state == DONE);
endmodule

// File: tb/tb_me_search_ctrl.sv
// tb/tb_me_search_ctrl.sv - randomized self-checking bench against a timeline model of the search sequence
module tb_me_search_ctrl;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] AddressR;
  logic [9:0] AddressS1;
  logic [9:0] AddressS2;
  logic       pe_valid, pe_first, pe_last, cmp_en, busy, completed;
  logic [3:0] cmp_vy;

  int total = 0;
  int bad   = 0;
  int g_cyc = 0;
  int q_cmp_cyc[$];
  int q_cmp_vy[$];

  // Model: 0 idle, 1 active with m_t = cycle number since the start edge, 2 done.
  int m_mode = 0;
  int m_t    = 0;

  me_search_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .AddressR(AddressR), .AddressS1(AddressS1), .AddressS2(AddressS2),
    .pe_valid(pe_valid), .pe_first(pe_first), .pe_last(pe_last),
    .cmp_en(cmp_en), .cmp_vy(cmp_vy), .busy(busy), .completed(completed)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) g_cyc <= g_cyc + 1;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mode <= 0;
      m_t    <= 0;
    end else begin
      case (m_mode)
        0: if (start) begin m_mode <= 1; m_t <= 1; end
        1: if (m_t == 4098) m_mode <= 2; else m_t <= m_t + 1;
        default: if (!start) m_mode <= 0;
      endcase
    end
  end

  int e_r, e_s1, e_s2, e_v, e_f, e_l, e_c, e_vy, e_b, e_d, n, vy, rr, cc;
  always @(negedge clock) begin
    e_r = 0; e_s1 = 0; e_s2 = 0; e_v = 0; e_f = 0; e_l = 0;
    e_c = 0; e_vy = 0; e_b = 0; e_d = 0;
    if (m_mode == 1) begin
      e_b = 1;
      if (m_t <= 4096) begin
        n    = m_t - 1;
        vy   = n / 256;
        rr   = (n / 16) % 16;
        cc   = n % 16;
        e_r  = n % 256;
        e_s1 = (vy + rr) * 31 + cc;
        e_s2 = e_s1 + 15;
      end
      if (m_t >= 2 && m_t <= 4097) begin
        e_v = 1;
        e_f = ((m_t - 2) % 256 == 0) ? 1 : 0;
        e_l = ((m_t - 2) % 256 == 255) ? 1 : 0;
      end
      if (m_t >= 3 && (m_t - 3) % 256 == 255) begin
        e_c  = 1;
        e_vy = (m_t - 3) / 256;
      end
    end else if (m_mode == 2) begin
      e_d = 1;
    end
    chk("AddressR", int'(AddressR), e_r);
    chk("AddressS1", int'(AddressS1), e_s1);
    chk("AddressS2", int'(AddressS2), e_s2);
    chk("pe_valid", int'(pe_valid), e_v);
    chk("pe_first", int'(pe_first), e_f);
    chk("pe_last", int'(pe_last), e_l);
    chk("cmp_en", int'(cmp_en), e_c);
    if (e_c == 1) chk("cmp_vy", int'(cmp_vy), e_vy);
    chk("busy", int'(busy), e_b);
    chk("completed", int'(completed), e_d);
    if (cmp_en) begin
      q_cmp_cyc.push_back(g_cyc);
      q_cmp_vy.push_back(int'(cmp_vy));
    end
  end

  // Called right after the start edge; walks cycles 1..4099 with literal corner checks.
  task automatic run_loop(input bit toggle);
    int e0c;
    e0c = 0;
    for (int k = 1; k <= 4099; k++) begin
      @(negedge clock);
      if (k == 1) e0c = g_cyc;
      if (toggle && k < 4097) start = 1'($urandom_range(0, 1));
      else start = 1'b1;
      case (k)
        1: begin
          chk("c1_AddressR", int'(AddressR), 0);
          chk("c1_S1", int'(AddressS1), 0);
          chk("c1_S2", int'(AddressS2), 15);
        end
        2: begin
          chk("c2_pe_valid", int'(pe_valid), 1);
          chk("c2_pe_first", int'(pe_first), 1);
        end
        256: begin
          chk("c256_AddressR", int'(AddressR), 255);
          chk("c256_S1", int'(AddressS1), 480);
          chk("c256_S2", int'(AddressS2), 495);
        end
        257: chk("c257_pe_last", int'(pe_last), 1);
        4096: begin
          chk("c4096_S1", int'(AddressS1), 945);
          chk("c4096_S2", int'(AddressS2), 960);
        end
        4097: chk("c4097_pe_last", int'(pe_last), 1);
        4098: begin
          chk("c4098_cmp_en", int'(cmp_en), 1);
          chk("c4098_completed", int'(completed), 0);
        end
        4099: begin
          chk("c4099_completed", int'(completed), 1);
          chk("c4099_busy", int'(busy), 0);
        end
        default: ;
      endcase
    end
    chk("cmp_count", q_cmp_cyc.size(), 16);
    for (int i = 0; i < q_cmp_cyc.size(); i++) begin
      chk("cmp_vy_order", q_cmp_vy[i], i);
      chk("cmp_cycle", q_cmp_cyc[i] - e0c + 1, 258 + 256 * i);
    end
  endtask

  task automatic clear_q();
    q_cmp_cyc.delete();
    q_cmp_vy.delete();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_AddressS2", int'(AddressS2), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_completed", int'(completed), 0);
    #2 reset = 1'b0;
    repeat (10) @(negedge clock);
    chk("idle_busy", int'(busy), 0);

    // Run 1: start held high, then DONE held for 50 cycles.
    clear_q();
    start = 1'b1;
    @(posedge clock);
    run_loop(1'b0);
    repeat (50) @(negedge clock);
    chk("hold_completed", int'(completed), 1);
    chk("hold_busy", int'(busy), 0);
    chk("hold_no_rerun", q_cmp_cyc.size(), 16);
    start = 1'b0;
    @(negedge clock);
    chk("drop_completed", int'(completed), 0);
    repeat ($urandom_range(1, 8)) @(negedge clock);

    // Run 2: asynchronous reset at cycle 1000, restart on release.
    start = 1'b1;
    @(posedge clock);
    repeat (1000) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_AddressR", int'(AddressR), 0);
    chk("arst_AddressS1", int'(AddressS1), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_pe_valid", int'(pe_valid), 0);
    chk("arst_cmp_en", int'(cmp_en), 0);
    @(negedge clock);
    #2 reset = 1'b0;
    clear_q();
    @(posedge clock);
    run_loop(1'b0);
    start = 1'b0;
    repeat ($urandom_range(2, 10)) @(negedge clock);

    // Run 3: start toggled randomly during RUN.
    clear_q();
    start = 1'b1;
    @(posedge clock);
    run_loop(1'b1);
    repeat ($urandom_range(1, 20)) @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    chk("end_idle_busy", int'(busy), 0);
    chk("end_no_extra_cmp", q_cmp_cyc.size(), 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/me_search_ctrl.md
# me_search_ctrl

Sequencing controller for the full-search block-matching motion estimator. It steps through all 16 vertical candidate offsets of a 16x16 reference block inside a 31x31 search window. For each step it drives the reference-ROM and search-ROM addresses and tells the 16-PE array and best-distance comparator when to clear, accumulate and compare. It sits between the top-level start/completed handshake and the PE datapath, replacing ad-hoc counter logic in the datapath.

## Interface
- BLK, 16, reference block edge in pixels (power of 2)
- WIN, 31, search window edge in pixels (2*BLK-1)
- AW_R, 8, reference address width (log2(BLK*BLK))
- AW_S, 10, search address width (ceil(log2(WIN*WIN)))

- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  level request; sampled only in IDLE and DONE
- AddressR  out  AW_R  reference ROM address
- AddressS1  out  AW_S  search ROM port 1 address
- AddressS2  out  AW_S  search ROM port 2 address
- pe_valid  out  1  ROM data on R/S1/S2 is valid this cycle
- pe_first  out  1  with pe_valid: first pixel of a pass (PE clears accumulators)
- pe_last  out  1  with pe_valid: last pixel of a pass
- cmp_en  out  1  comparator samples PE sums this cycle
- cmp_vy  out  4  vertical offset of the pass being compared
- busy  out  1  high in RUN and DRAIN
- completed  out  1  search finished; held in DONE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when start=1. cnt <= 0.
- RUN: cnt (12 b) increments each cycle. vy=cnt[11:8], r=cnt[7:4], c=cnt[3:0].
  - AddressR = cnt[7:0].
  - AddressS1 = (vy+r)*WIN + c.
  - AddressS2 = (vy+r)*WIN + c + BLK-1.
  - Maxima are 945 and 960; no wrap and no overflow of AW_S.
- RUN -> DRAIN after cnt=4095 is issued.
- DRAIN lasts 2 cycles, then goes to DONE.
- DONE: completed=1. DONE -> IDLE when start=0. While start stays 1, DONE holds; no auto-restart.
- Outside RUN, all address outputs are 0.
- start changes in RUN or DRAIN are ignored.
- Address arithmetic is unsigned, computed at AW_S+1 bits and truncated to AW_S bits.

## Timing
- ROMs have a 1-cycle registered read.
  - pe_valid, pe_first and pe_last are the RUN-issue flags delayed 1 cycle.
  - pe_first marks cnt[7:0]=0; pe_last marks cnt[7:0]=255.
- cmp_en pulses 1 cycle after each pe_last (PE accumulate latency 1). cmp_vy carries that pass's vy.
- Take edge E0 as the edge where IDLE samples start=1:
  - addresses for cnt=0..4095 are valid in cycles 1..4096;
  - pe_valid is high in cycles 2..4097;
  - cmp_en fires 16 times, with the last in cycle 4098;
  - completed rises in cycle 4099.
- Reset values: state=IDLE, cnt=0, every output 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Pipeline flags are cleared too, so no stray cmp_en occurs after release.
- When reset is released with start=1, RUN begins on the first rising edge after release.

## Structure
- Shared package me_pkg holds:
  - BLK, WIN, AW_R, AW_S;
  - the state enum me_state_t {IDLE, RUN, DRAIN, DONE};
  - the PE and comparator latencies as localparams (1 and 1).
- One sub-module, me_addr_gen: a registered-free decode of cnt into AddressR, AddressS1 and AddressS2, plus first/last flags. The FSM, counter and delay pipeline stay in me_search_ctrl.

## Test plan
- Reset, then idle with start=0 for 10 cycles -> all outputs 0, busy=0.
- Raise start at E0 -> cycle 1: AddressR=0, S1=0, S2=15. Cycle 2: pe_valid=1, pe_first=1.
- Check the cnt=255 and cnt=4095 corners:
  - cnt=255 -> AddressR=255, S1=480, S2=495;
  - cnt=4095 -> S1=945, S2=960;
  - pe_last is seen the following cycle in each case.
- Full run with start held high -> 16 cmp_en pulses, cmp_vy=0..15 in order, 256 cycles apart. completed=1 from cycle 4099 and held until start=0, then completed=0 one cycle later.
- Assert reset asynchronously at cycle 1000 -> outputs 0 before the next edge. Release with start=1 -> new run restarts at AddressR=0, and exactly 16 cmp_en follow.
- Toggle start during RUN -> no effect, with the completion cycle unchanged. Holding start=1 in DONE for 50 cycles -> no second run begins.
